parallel_out_bank: RTL
======================

# parallel_out_bank

Memory-mapped bank of N_CH registered parallel output channels sitting on the CPU data-memory write path. Writes that fall inside the port window are steered to per-channel output registers, each with a valid/ack handshake to the attached peripheral and a sticky overrun flag. All other writes are forwarded to data memory via `wren`. Generalises the single fixed-address output port to parametrised width, channel count and base address, with a handshake and status the single port lacks.

## Interface

Parameters:
- `DATA_W`, 8: data width of the bus and of each channel.
- `ADDR_W`, 8: address width.
- `N_CH`, 4: number of output channels, 1..DATA_W.
- `BASE`, 8'hFB: address of channel 0.
  - Channel i is at BASE+i.
  - The control/status address is CTRL = BASE+N_CH.
  - Required: CTRL ≤ 2^ADDR_W−1.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Address` in ADDR_W: CPU data address.
- `RegData` in DATA_W: CPU write data.
- `we` in 1: CPU write enable.
- `wren` out 1: data-memory write enable.
- `DataOut` out N_CH*DATA_W: channel registers; channel i occupies bits [i*DATA_W +: DATA_W].
- `out_valid` out N_CH: per-channel "new data" flag.
- `out_ack` in N_CH: per-channel consume acknowledge from the peripheral.
- `overrun` out N_CH: sticky per-channel overrun flags.
- `rd_data` out DATA_W: readback of the addressed port register (see Configuration).

## Operation

- Window: BASE ≤ Address ≤ CTRL. Two decodes:
  - `hit_ch`: Address in [BASE, BASE+N_CH−1]; channel index = Address−BASE.
  - `hit_ctrl`: Address == CTRL.
- `wren` is combinational: `we & ~(hit_ch | hit_ctrl)`. A window address never writes memory.
- Write stage register (`stg_v`, `stg_ctrl`, `stg_idx`, `stg_data`):
  - Loaded every edge with `we & (hit_ch | hit_ctrl)`, the decode result and `RegData`.
  - Cleared when no window write is present.
- Commit (edge after capture, when `stg_v`):
  - Channel write: `DataOut[stg_idx] ← stg_data`, `out_valid[stg_idx] ← 1`.
  - Control write: write-1-to-clear. `overrun[i] ← 0` wherever `stg_data[i] == 1`. No effect on DataOut or out_valid.
- Handshake, per channel on each edge:
  - `out_ack[i] & out_valid[i]` clears `out_valid[i]`.
  - `out_ack` while `out_valid` is low is ignored.
- Simultaneous events, channel i:
  - Commit with valid=1 and no ack: data overwritten (newest wins), valid stays 1, `overrun[i] ← 1`.
  - Commit with ack in the same edge: data overwritten, valid stays 1, no overrun.
  - Commit with valid=0: data written, valid ← 1, no overrun.
  - Control clear of `overrun[i]` in the same edge as a new overrun on i: set wins, overrun stays 1.
- Back-to-back window writes are accepted every cycle (the stage is a pipeline register, not a buffer). Two consecutive writes to the same channel with no ack set overrun.

## Timing

- Reset (asynchronous, `rst_n` = 0):
  - DataOut = 0, out_valid = 0, overrun = 0, stage cleared.
  - `wren` follows its combinational equation.
- Reset mid-operation: a staged but uncommitted write is discarded.
- Latency: window write sampled at edge T → DataOut/out_valid/overrun updated at edge T+1.
- `wren` is asserted in the same cycle as `we`, with zero latency.
- `out_ack` is sampled at the edge; `out_valid` falls at that edge.

## Configuration

- `PAR_OUT_READBACK_EN`
  - Defined: `rd_data` is combinational.
    - Channel address: that channel's DataOut.
    - CTRL: `{out_valid, overrun}` packed as overrun in bits [N_CH−1:0] and out_valid in bits [2*N_CH−1:N_CH] when 2*N_CH ≤ DATA_W; otherwise overrun only, zero-extended.
    - Any other address: 0.
    - Independent of `we`.
  - Not defined: `rd_data` is tied to 0. No readback mux is synthesised.

## Test plan

- Reset: `rst_n`=0 mid-sequence → DataOut=0, out_valid=0, overrun=0 immediately, without waiting for a clock edge.
- Memory pass-through: we=1, Address=8'h10 → wren=1 same cycle. Address=8'hFD → wren=0, and after one edge DataOut[2]=RegData (8'hA5), out_valid=4'b0100.
- Handshake: write 8'h3C to 8'hFB, then out_ack[0]=1 for one cycle → out_valid[0] falls at that edge, DataOut[0] holds 8'h3C.
- Overrun: two consecutive writes to 8'hFC (8'h11, 8'h22) with no ack → DataOut[1]=8'h22, out_valid[1]=1, overrun[1]=1. Repeat with out_ack[1]=1 on the second commit edge → overrun[1]=0.
- W1C status: overrun=4'b1010, write 8'h02 to 8'hFF → overrun=4'b1000, and wren=0 throughout. Repeat with a new overrun on channel 1 at the same edge → overrun[1] stays 1.
- Readback (macro defined): Address=8'hFE after writing 8'h5A there → rd_data=8'h5A. With the macro undefined → rd_data=0.

Source files
------------

// File: rtl/parallel_out_bank.sv
// +----------------------------------------------------------------------------+
// | parallel_out_bank: memory-mapped bank of N_CH registered output channels    |
// | with valid/ack handshake, sticky overrun flags and a W1C control address.    |
// | Optional readback mux: define PAR_OUT_READBACK_EN.                           |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module parallel_out_bank #(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                N_CH   = 4,
  parameter logic [ADDR_W-1:0] BASE   = 8'hFB
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [DATA_W-1:0]        RegData,
  input  logic                     we,
  output logic                     wren,
  output logic [N_CH*DATA_W-1:0]   DataOut,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ack,
  output logic [N_CH-1:0]          overrun,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int                c_idx_w = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W-1:0] c_last  = BASE + ADDR_W'(N_CH - 1);
  localparam logic [ADDR_W-1:0] c_ctrl  = BASE + ADDR_W'(N_CH);

  logic               w_hit_ch;
  logic               w_hit_ctrl;
  logic               w_win_wr;
  logic [c_idx_w-1:0] w_idx;
  logic [N_CH-1:0]    w_ch_sel;
  logic [N_CH-1:0]    w_ovr_set;
  logic [N_CH-1:0]    w_ovr_clr;
  logic [N_CH-1:0]    w_valid_nxt;

  logic                   r_stg_v;
  logic                   r_stg_ctrl;
  logic [c_idx_w-1:0]     r_stg_idx;
  logic [DATA_W-1:0]      r_stg_data;
  logic [N_CH*DATA_W-1:0] r_data;
  logic [N_CH-1:0]        r_valid;
  logic [N_CH-1:0]        r_ovr;

  assign w_hit_ch   = (Address >= BASE) && (Address <= c_last);
  assign w_hit_ctrl = (Address == c_ctrl);
  assign w_win_wr   = we & (w_hit_ch | w_hit_ctrl);
  assign w_idx      = c_idx_w'(Address - BASE);
  assign wren       = we & ~(w_hit_ch | w_hit_ctrl);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_ch_sel[gi]  = r_stg_v & ~r_stg_ctrl & (r_stg_idx == c_idx_w'(gi));
      // Overwriting unconsumed data is an overrun unless the same edge acks it.
      assign w_ovr_set[gi] = w_ch_sel[gi] & r_valid[gi] & ~out_ack[gi];
    end
  endgenerate

  assign w_ovr_clr   = (r_stg_v & r_stg_ctrl) ? r_stg_data[N_CH-1:0] : '0;
  assign w_valid_nxt = (r_valid & ~out_ack) | w_ch_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_v    <= 1'b0;
      r_stg_ctrl <= 1'b0;
      r_stg_idx  <= '0;
      r_stg_data <= '0;
      r_data     <= '0;
      r_valid    <= '0;
      r_ovr      <= '0;
    end else begin
      r_stg_v    <= w_win_wr;
      r_stg_ctrl <= w_win_wr & w_hit_ctrl;
      r_stg_idx  <= w_win_wr ? w_idx : '0;
      r_stg_data <= w_win_wr ? RegData : '0;
      for (int i = 0; i < N_CH; i++) begin
        if (w_ch_sel[i]) r_data[i*DATA_W +: DATA_W] <= r_stg_data;
      end
      r_valid    <= w_valid_nxt;
      // Set has priority over a simultaneous W1C clear.
      r_ovr      <= (r_ovr & ~w_ovr_clr) | w_ovr_set;
    end
  end

  assign DataOut   = r_data;
  assign out_valid = r_valid;
  assign overrun   = r_ovr;

`ifdef PAR_OUT_READBACK_EN
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd;

  generate
    if (2 * N_CH <= DATA_W) begin : g_rb_wide
      assign w_status = DATA_W'({r_valid, r_ovr});
    end else begin : g_rb_narrow
      assign w_status = DATA_W'(r_ovr);
    end
  endgenerate

  always_comb begin
    w_rd = '0;
    if (w_hit_ch)        w_rd = r_data[w_idx*DATA_W +: DATA_W];
    else if (w_hit_ctrl) w_rd = w_status;
  end

  assign rd_data = w_rd;
`else
  assign rd_data = '0;
`endif

endmodule

`default_nettype wire
